mshr_file: RTL
==============

// Module: mshr_file
// PURPOSE
//  Parametrised miss-status holding register file between the L1 cache and memory. Tracks up to
//  ENTRIES outstanding line misses, merges secondary misses to an in-flight line, issues one
//  memory request per line, and returns each refilled line to the cache with its merged miss count.
// PARAMETERS
//  ENTRIES   4    number of MSHR entries (>=2)
//  ADDR_W    32   byte address width
//  OFFSET_W  4    line offset bits (line = 2**OFFSET_W bytes)
//  LINE_W    128  refill data width, one beat per line
//  MAX_TGT   4    max misses (primary + merged) per entry
//  Derived: IDX_W=$clog2(ENTRIES), CNT_W=$clog2(MAX_TGT+1)
// PORTS
//  clk               in   1       clock
//  rst               in   1       reset: synchronous, active-high
//  miss_valid_i      in   1       cache miss request
//  miss_ready_o      out  1       miss accepted when valid&ready
//  miss_addr_i       in   ADDR_W  miss byte address
//  mem_req_valid_o   out  1       memory read request
//  mem_req_ready_i   in   1       memory accepts request
//  mem_req_addr_o    out  ADDR_W  line address, offset bits zero
//  mem_req_id_o      out  IDX_W   entry index, echoed in response
//  mem_resp_valid_i  in   1       refill beat (always accepted)
//  mem_resp_id_i     in   IDX_W   entry index of refill
//  mem_resp_data_i   in   LINE_W  refill line
//  cache_resp_valid_o out 1       refilled line to cache
//  cache_resp_ready_i in  1       cache accepts line
//  cache_resp_addr_o out  ADDR_W  line address, offset zero
//  cache_resp_data_o out  LINE_W  line data
//  cache_resp_cnt_o  out  CNT_W   misses covered, 1..MAX_TGT
//  full_o            out  1       no FREE entry
//  proto_err_o       out  1       one-cycle pulse: refill for entry not in WAIT
// BEHAVIOUR
//  Reset: all entries FREE, cnt=0; all valid outputs, full_o, proto_err_o = 0; data outputs 0.
//  Entry FSM: FREE -> PEND (allocated) -> WAIT (mem req handshaked) -> READY (refill stored)
//   -> FREE (cache resp handshaked). Line tag compare = miss_addr_i[ADDR_W-1:OFFSET_W].
//  miss_ready_o (combinational from registered state + miss_addr_i):
//   - tag matches PEND/WAIT entry: ready iff its cnt<MAX_TGT; accept -> cnt+1 (merge).
//   - tag matches READY entry: ready=0 (stall until delivered).
//   - no match: ready iff a FREE entry exists; accept -> lowest-index FREE entry, PEND, cnt=1.
//  Latency: miss accepted cycle N -> mem_req_valid_o earliest N+1. Refill at cycle M ->
//   cache_resp_valid_o earliest M+1. Entry freed at handshake edge, allocatable next cycle.
//  Mem request: lowest-index PEND entry selected; selection locked while valid&!ready;
//   addr/id stable until handshake. Cache resp: same rule over READY entries.
//  Simultaneous: merge in same cycle as refill for that entry -> both apply (cnt+1, READY).
//   Merge in same cycle as mem req handshake -> both apply. Free and allocate same cycle:
//   freed slot not visible to allocation until next cycle.
//  mem_resp to entry not in WAIT: data dropped, no state change, proto_err_o=1 next cycle.
//  Reset mid-operation: all entries FREE immediately; late refills raise proto_err_o.
//  full_o = no FREE entry (registered state). cnt saturates at MAX_TGT, never wraps.
// STRUCTURE
//  Package mshr_pkg: entry state encoding (FREE/PEND/WAIT/READY), clog2 helper.
//  Sub-module mshr_entry: one entry FSM + tag/cnt/data registers, instantiated ENTRIES times;
//  top holds tag match, lowest-index priority encoders and the two arbitration locks.
// TESTING
//  1 Miss 0x1000, mem ready=1 -> mem_req addr 0x1000 id0 next cycle; refill id0 D -> cache_resp
//    addr 0x1000 data D cnt=1, entry freed, full_o=0.
//  2 Misses 0x1004,0x1008,0x100C after 0x1000 in WAIT -> all accepted, one mem req only,
//    cache_resp cnt=4; fifth miss 0x1000 before refill -> miss_ready_o=0.
//  3 Four misses 0x0,0x40,0x80,0xC0 -> full_o=1, miss 0x100 stalls; refill id2 + cache ready
//    -> next cycle full_o=0, 0x100 allocated to entry 2.
//  4 mem_req_ready_i=0 for 5 cycles with two PEND -> addr/id held on entry 0; then entry 1.
//  5 cache_resp_ready_i=0 while lower-index entry becomes READY -> output stays on locked entry.
//  6 Refill id3 with entry 3 FREE -> proto_err_o pulse 1 cycle, no cache_resp; rst mid-WAIT ->
//    all outputs 0, later refill raises proto_err_o.

Source files
------------

// File: rtl/mshr_pkg.sv
// rtl/mshr_pkg.sv - shared types and helpers for the MSHR file
// Contents:
//   entry_state_t : per-entry lifecycle FREE -> PEND -> WAIT -> READY -> FREE
//   clog2()       : constant-safe ceiling log2 for derived widths
package mshr_pkg;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READY = 2'd3
    } entry_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mshr_entry.sv
// rtl/mshr_entry.sv - one MSHR entry: lifecycle FSM plus tag, miss count and line data
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   alloc          : claim this FREE entry for alloc_tag (cnt starts at 1)
//   merge          : secondary miss to this entry's line (cnt+1, saturating)
//   req_fire       : memory request for this entry handshaked (PEND -> WAIT)
//   refill         : refill beat for this entry, refill_data captured (WAIT -> READY)
//   deliver        : line handed to the cache (READY -> FREE)
//   state/tag/cnt/data : registered entry contents
module mshr_entry
    import mshr_pkg::*;
#(
    parameter int TAG_W   = 28,
    parameter int LINE_W  = 128,
    parameter int MAX_TGT = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic              merge,
    input  logic              req_fire,
    input  logic              refill,
    input  logic              deliver,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic [LINE_W-1:0] refill_data,
    output entry_state_t      state,
    output logic [TAG_W-1:0]  tag,
    output logic [CNT_W-1:0]  cnt,
    output logic [LINE_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FREE;
            tag   <= '0;
            cnt   <= '0;
            data  <= '0;
        end else begin
            case (state)
                ST_FREE: if (alloc) begin
                    state <= ST_PEND;
                    tag   <= alloc_tag;
                    cnt   <= CNT_W'(1);
                end
                ST_PEND:  if (req_fire) state <= ST_WAIT;
                ST_WAIT:  if (refill) begin
                    state <= ST_READY;
                    data  <= refill_data;
                end
                ST_READY: if (deliver) begin
                    state <= ST_FREE;
                    cnt   <= '0;
                end
                default:  state <= ST_FREE;
            endcase
            // Merges may coincide with the request handshake or the refill; the
            // state transition above never touches cnt in PEND/WAIT, so both apply.
            if (merge && (state == ST_PEND || state == ST_WAIT) && cnt < CNT_W'(MAX_TGT))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mshr_file.sv
// rtl/mshr_file.sv - miss-status holding register file between L1 cache and memory
// Ports:
//   miss_*        : miss request in (valid/ready, byte address)
//   mem_req_*     : one read request per line out (valid/ready, line address, entry id)
//   mem_resp_*    : refill beat in (always accepted, entry id, line data)
//   cache_resp_*  : refilled line out (valid/ready, line address, data, merged miss count)
//   full_o        : no FREE entry
//   proto_err_o   : one-cycle pulse after a refill to an entry not in WAIT
module mshr_file
    import mshr_pkg::*;
#(
    parameter int ENTRIES  = 4,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    parameter int LINE_W   = 128,
    parameter int MAX_TGT  = 4,
    parameter int IDX_W    = clog2(ENTRIES),
    parameter int CNT_W    = clog2(MAX_TGT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid_i,
    output logic              miss_ready_o,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [IDX_W-1:0]  mem_req_id_o,
    input  logic              mem_resp_valid_i,
    input  logic [IDX_W-1:0]  mem_resp_id_i,
    input  logic [LINE_W-1:0] mem_resp_data_i,
    output logic              cache_resp_valid_o,
    input  logic              cache_resp_ready_i,
    output logic [ADDR_W-1:0] cache_resp_addr_o,
    output logic [LINE_W-1:0] cache_resp_data_o,
    output logic [CNT_W-1:0]  cache_resp_cnt_o,
    output logic              full_o,
    output logic              proto_err_o
);

    localparam int TAG_W = ADDR_W - OFFSET_W;

    entry_state_t      st   [ENTRIES];
    logic [TAG_W-1:0]  tags [ENTRIES];
    logic [CNT_W-1:0]  cnts [ENTRIES];
    logic [LINE_W-1:0] datas[ENTRIES];

    logic [ENTRIES-1:0] alloc, merge, req_fire, refill, deliver;

    logic [TAG_W-1:0] miss_tag;
    logic             unused_offset;
    assign miss_tag      = miss_addr_i[ADDR_W-1:OFFSET_W];
    assign unused_offset = ^miss_addr_i[OFFSET_W-1:0];

    logic             hit_act, hit_rdy, free_any, pend_any, rdy_any, resp_ok;
    logic [IDX_W-1:0] hit_idx, free_idx, pend_idx, rdy_idx;

    // Tags are unique among live entries (a matching miss never allocates),
    // so at most one entry can hit. Descending scan leaves the lowest index.
    always_comb begin
        hit_act  = 1'b0;
        hit_rdy  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        pend_any = 1'b0;
        pend_idx = '0;
        rdy_any  = 1'b0;
        rdy_idx  = '0;
        resp_ok  = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (st[i] != ST_FREE && tags[i] == miss_tag) begin
                hit_idx = IDX_W'(i);
                if (st[i] == ST_READY) hit_rdy = 1'b1;
                else                   hit_act = 1'b1;
            end
            if (st[i] == ST_FREE)  begin free_any = 1'b1; free_idx = IDX_W'(i); end
            if (st[i] == ST_PEND)  begin pend_any = 1'b1; pend_idx = IDX_W'(i); end
            if (st[i] == ST_READY) begin rdy_any  = 1'b1; rdy_idx  = IDX_W'(i); end
            if (mem_resp_id_i == IDX_W'(i) && st[i] == ST_WAIT) resp_ok = 1'b1;
        end
    end

    assign miss_ready_o = hit_act ? (cnts[hit_idx] < CNT_W'(MAX_TGT)) : (!hit_rdy && free_any);

    // Once an output is offered and stalled, keep offering the same entry so
    // address/id stay stable until the handshake even if a lower index qualifies.
    logic             req_locked, rsp_locked;
    logic [IDX_W-1:0] req_lock_idx, rsp_lock_idx;
    logic [IDX_W-1:0] req_idx, rsp_idx;

    assign req_idx            = req_locked ? req_lock_idx : pend_idx;
    assign rsp_idx            = rsp_locked ? rsp_lock_idx : rdy_idx;
    assign mem_req_valid_o    = req_locked || pend_any;
    assign cache_resp_valid_o = rsp_locked || rdy_any;

    assign mem_req_addr_o    = mem_req_valid_o ? {tags[req_idx], {OFFSET_W{1'b0}}} : '0;
    assign mem_req_id_o      = mem_req_valid_o ? req_idx : '0;
    assign cache_resp_addr_o = cache_resp_valid_o ? {tags[rsp_idx], {OFFSET_W{1'b0}}} : '0;
    assign cache_resp_data_o = cache_resp_valid_o ? datas[rsp_idx] : '0;
    assign cache_resp_cnt_o  = cache_resp_valid_o ? cnts[rsp_idx] : '0;
    assign full_o            = !free_any;

    always_comb begin
        alloc   = '0;
        merge   = '0;
        req_fire = '0;
        refill  = '0;
        deliver = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            alloc[i]    = miss_valid_i && miss_ready_o && !hit_act && free_idx == IDX_W'(i);
            merge[i]    = miss_valid_i && miss_ready_o && hit_act && hit_idx == IDX_W'(i);
            req_fire[i] = mem_req_valid_o && mem_req_ready_i && req_idx == IDX_W'(i);
            refill[i]   = mem_resp_valid_i && resp_ok && mem_resp_id_i == IDX_W'(i);
            deliver[i]  = cache_resp_valid_o && cache_resp_ready_i && rsp_idx == IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_locked   <= 1'b0;
            req_lock_idx <= '0;
            rsp_locked   <= 1'b0;
            rsp_lock_idx <= '0;
            proto_err_o  <= 1'b0;
        end else begin
            req_locked   <= mem_req_valid_o && !mem_req_ready_i;
            req_lock_idx <= req_idx;
            rsp_locked   <= cache_resp_valid_o && !cache_resp_ready_i;
            rsp_lock_idx <= rsp_idx;
            proto_err_o  <= mem_resp_valid_i && !resp_ok;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        mshr_entry #(
            .TAG_W   (TAG_W),
            .LINE_W  (LINE_W),
            .MAX_TGT (MAX_TGT),
            .CNT_W   (CNT_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .alloc       (alloc[g]),
            .merge       (merge[g]),
            .req_fire    (req_fire[g]),
            .refill      (refill[g]),
            .deliver     (deliver[g]),
            .alloc_tag   (miss_tag),
            .refill_data (mem_resp_data_i),
            .state       (st[g]),
            .tag         (tags[g]),
            .cnt         (cnts[g]),
            .data        (datas[g])
        );
    end

endmodule
